// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared width constants and the arbiter state type. spi_interface uses the
// same width constants, so the latched fields connect straight across.
//   META_W   : meta byte width
//   PREFIX_W : name prefix width
//   DATA_W   : payload width
//   arb_state_t : IDLE / LAUNCH / WAIT
// -----------------------------------------------------------------------------
package spi_pkg;

   localparam int META_W   = 8;
   localparam int PREFIX_W = 64;
   localparam int DATA_W   = 256;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LAUNCH = 2'd1,
      WAIT   = 2'd2
   } arb_state_t;

endpackage : spi_pkg

// File: rtl/spi_rr_arbiter.sv
// -----------------------------------------------------------------------------
// spi_rr_arbiter
// Combinational round-robin selector. The search starts at rr_ptr and wraps
// modulo N_REQ. The first valid requester found wins.
// Ports:
//   req_valid [N_REQ]        : pending requests
//   rr_ptr    [clog2(N_REQ)] : highest-priority index for this search
//   grant     [N_REQ]        : one-hot winner (0 when nothing is valid)
//   grant_idx [clog2(N_REQ)] : encoded winner index (0 when nothing is valid)
//   any_valid                : at least one requester is valid
// -----------------------------------------------------------------------------
module spi_rr_arbiter #(
   parameter int N_REQ = 4
) (
   input  logic [N_REQ-1:0]         req_valid,
   input  logic [$clog2(N_REQ)-1:0] rr_ptr,
   output logic [N_REQ-1:0]         grant,
   output logic [$clog2(N_REQ)-1:0] grant_idx,
   output logic                     any_valid
);

   localparam int IDX_W = $clog2(N_REQ);

   // The sum is one bit wider than an index, so ptr + offset (< 2*N_REQ)
   // cannot overflow before the modulo fold.
   logic [IDX_W:0]   sum;
   logic [IDX_W-1:0] cand;

   always_comb begin
      grant     = '0;
      grant_idx = '0;
      any_valid = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int k = 0; k < N_REQ; k++) begin
         sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
         if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
         end
         cand = sum[IDX_W-1:0];
         if (!any_valid && req_valid[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            any_valid   = 1'b1;
         end
      end
   end

endmodule : spi_rr_arbiter

// File: rtl/spi_tx_arbiter.sv
// -----------------------------------------------------------------------------
// spi_tx_arbiter
// Shares the single spi_interface transmit path among N_REQ packet sources.
// A granted packet is latched, launched with a one-cycle TX_valid pulse, and
// the link is held until spi_interface reports tx_done.
//
// Optional feature macro: SPI_ARB_TIMEOUT_EN
//   When it is defined, a watchdog abandons a WAIT after TIMEOUT_CYCLES cycles
//   without tx_done and pulses timeout_err. When it is undefined, WAIT lasts
//   until tx_done and timeout_err is tied to 0.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid / req_ready    : per-requester handshake (see below)
//   req_meta/prefix/data     : per-requester fields, requester i at [i*W +: W]
//   TX_valid                 : one-cycle launch pulse to spi_interface
//   packet_*_input           : latched fields, stable from grant to next grant
//   tx_done                  : completion pulse from spi_interface
//   grant_id                 : index of the current/last link owner
//   busy                     : registered, high in LAUNCH and WAIT
//   timeout_err              : one-cycle watchdog pulse
//   tx_count                 : completed packets, wraps at 16 bits
//   fsm_state                : current state, for observation
//
// Handshake: req_ready is combinational and one-hot, nonzero only in IDLE.
// A packet transfers on the rising edge where req_valid[i] & req_ready[i].
// req_ready never depends on anything other than state, rr_ptr and
// req_valid. A requester may hold req_valid for as long as it likes.
// -----------------------------------------------------------------------------
module spi_tx_arbiter
   import spi_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [N_REQ-1:0]             req_valid,
   output logic [N_REQ-1:0]             req_ready,
   input  logic [N_REQ*META_W-1:0]      req_meta,
   input  logic [N_REQ*PREFIX_W-1:0]    req_prefix,
   input  logic [N_REQ*DATA_W-1:0]      req_data,
   output logic                         TX_valid,
   output logic [META_W-1:0]            packet_meta_data_input,
   output logic [PREFIX_W-1:0]          packet_prefix_input,
   output logic [DATA_W-1:0]            packet_data_input,
   input  logic                         tx_done,
   output logic [$clog2(N_REQ)-1:0]     grant_id,
   output logic                         busy,
   output logic                         timeout_err,
   output logic [15:0]                  tx_count,
   output arb_state_t                   fsm_state
);

   localparam int IDX_W = $clog2(N_REQ);

   arb_state_t         state;
   arb_state_t         next_state;
   logic [IDX_W-1:0]   rr_ptr;

   logic [N_REQ-1:0]   arb_grant;
   logic [IDX_W-1:0]   arb_idx;
   logic               arb_any;
   logic               wd_expire;

   logic [META_W-1:0]   sel_meta;
   logic [PREFIX_W-1:0] sel_prefix;
   logic [DATA_W-1:0]   sel_data;

   logic grant_fire;

   spi_rr_arbiter #(
      .N_REQ (N_REQ)
   ) u_rr (
      .req_valid (req_valid),
      .rr_ptr    (rr_ptr),
      .grant     (arb_grant),
      .grant_idx (arb_idx),
      .any_valid (arb_any)
   );

   assign fsm_state  = state;
   assign grant_fire = (state == IDLE) && arb_any;

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic. Completion wins over the watchdog when both land
   // in the same WAIT cycle.
   always_comb begin
      next_state = state;
      case (state)
         IDLE:    if (arb_any) next_state = LAUNCH;
         LAUNCH:  next_state = WAIT;
         WAIT: begin
            if (tx_done) begin
               next_state = IDLE;
            end else if (wd_expire) begin
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Output logic
   always_comb begin
      req_ready = '0;
      TX_valid  = 1'b0;
      case (state)
         IDLE:    req_ready = arb_grant;
         LAUNCH:  TX_valid  = 1'b1;
         default: ;
      endcase
   end

   // Field mux driven by the one-hot grant.
   always_comb begin
      sel_meta   = '0;
      sel_prefix = '0;
      sel_data   = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (arb_grant[i]) begin
            sel_meta   = req_meta[i*META_W +: META_W];
            sel_prefix = req_prefix[i*PREFIX_W +: PREFIX_W];
            sel_data   = req_data[i*DATA_W +: DATA_W];
         end
      end
   end

   // Output registers, round-robin pointer, completion counter and busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         packet_meta_data_input <= '0;
         packet_prefix_input    <= '0;
         packet_data_input      <= '0;
         grant_id               <= '0;
         rr_ptr                 <= '0;
         tx_count               <= '0;
         busy                   <= 1'b0;
      end else begin
         if (grant_fire) begin
            packet_meta_data_input <= sel_meta;
            packet_prefix_input    <= sel_prefix;
            packet_data_input      <= sel_data;
            grant_id               <= arb_idx;
            // The winner moves to lowest priority for the next search.
            if (arb_idx == IDX_W'(N_REQ - 1)) begin
               rr_ptr <= '0;
            end else begin
               rr_ptr <= arb_idx + IDX_W'(1);
            end
         end
         if ((state == WAIT) && tx_done) begin
            tx_count <= tx_count + 16'd1;
         end
         busy <= (next_state != IDLE);
      end
   end

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] wd_cnt;

   // wd_cnt counts completed WAIT cycles. The cycle that finds it at
   // TIMEOUT_CYCLES-1 is the one in which it reaches TIMEOUT_CYCLES.
   assign wd_expire = (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt      <= '0;
         timeout_err <= 1'b0;
      end else begin
         timeout_err <= (state == WAIT) && !tx_done && wd_expire;
         if (state == LAUNCH) begin
            wd_cnt <= '0;
         end else if ((state == WAIT) && !tx_done) begin
            wd_cnt <= wd_cnt + WD_W'(1);
         end
      end
   end
`else
   assign wd_expire   = 1'b0;
   assign timeout_err = 1'b0;
`endif

endmodule : spi_tx_arbiter

// File: tb/tb_spi_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_tx_arbiter
// Directed bench for spi_tx_arbiter (N_REQ=4, TIMEOUT_CYCLES=16). Inputs are
// driven and outputs sampled on the falling edge. A launch monitor checks
// every TX_valid pulse against an expected {grant_id, meta} queue. The
// watchdog section follows SPI_ARB_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_spi_tx_arbiter;
   import spi_pkg::*;

   localparam int N   = 4;
   localparam int TO  = 16;
   localparam int EXP_W = 2 + META_W;
`ifdef SPI_ARB_TIMEOUT_EN
   localparam int T1_WAIT = 10;
`else
   localparam int T1_WAIT = 48;
`endif

   // ---------------- clock / reset and DUT ----------------
   logic                    clk = 1'b0;
   logic                    rst = 1'b1;
   logic [N-1:0]            req_valid = '0;
   logic [N-1:0]            req_ready;
   logic [N*META_W-1:0]     req_meta = '0;
   logic [N*PREFIX_W-1:0]   req_prefix = '0;
   logic [N*DATA_W-1:0]     req_data = '0;
   logic                    TX_valid;
   logic [META_W-1:0]       packet_meta_data_input;
   logic [PREFIX_W-1:0]     packet_prefix_input;
   logic [DATA_W-1:0]       packet_data_input;
   logic                    tx_done = 1'b0;
   logic [1:0]              grant_id;
   logic                    busy;
   logic                    timeout_err;
   logic [15:0]             tx_count;
   arb_state_t              fsm_state;

   int checks = 0;
   int errors = 0;
   logic [EXP_W-1:0] exp_q[$];

   always #5 clk = ~clk;

   spi_tx_arbiter #(
      .N_REQ          (N),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk                    (clk),
      .rst                    (rst),
      .req_valid              (req_valid),
      .req_ready              (req_ready),
      .req_meta               (req_meta),
      .req_prefix             (req_prefix),
      .req_data               (req_data),
      .TX_valid               (TX_valid),
      .packet_meta_data_input (packet_meta_data_input),
      .packet_prefix_input    (packet_prefix_input),
      .packet_data_input      (packet_data_input),
      .tx_done                (tx_done),
      .grant_id               (grant_id),
      .busy                   (busy),
      .timeout_err            (timeout_err),
      .tx_count               (tx_count),
      .fsm_state              (fsm_state)
   );

   // ---------------- checking ----------------
   task automatic check_val(input string tag, input logic [255:0] obs,
                            input logic [255:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic apply_reset();
      tick();
      rst       = 1'b1;
      req_valid = '0;
      tx_done   = 1'b0;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic set_req(input int i, input logic [META_W-1:0] m,
                          input logic [PREFIX_W-1:0] p,
                          input logic [DATA_W-1:0] d);
      req_meta[i*META_W +: META_W]       = m;
      req_prefix[i*PREFIX_W +: PREFIX_W] = p;
      req_data[i*DATA_W +: DATA_W]       = d;
   endtask

   function automatic logic [META_W-1:0] meta_of(input int i);
      return META_W'(8'h10 + i);
   endfunction

   task automatic load_all();
      for (int i = 0; i < N; i++) begin
         set_req(i, meta_of(i), PREFIX_W'(64'h1000 + i),
                 DATA_W'(256'hABCD_0000 + i));
      end
   endtask

   task automatic expect_launch(input int idx, input logic [META_W-1:0] m);
      exp_q.push_back({2'(idx), m});
   endtask

   // Waits at most max_cycles falling edges for TX_valid.
   task automatic wait_launch(input int max_cycles);
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < max_cycles && !seen; c++) begin
         tick();
         if (TX_valid) seen = 1'b1;
      end
      check_val("launch_seen", 256'(seen), 256'(1));
   endtask

   task automatic pulse_done();
      tx_done = 1'b1;
      tick();
      tx_done = 1'b0;
   endtask

   // ---------------- scoreboard: launch monitor ----------------
   always @(negedge clk) begin
      if (!rst && TX_valid) begin
         if (exp_q.size() == 0) begin
            check_val("unexpected_launch", 256'(1), 256'(0));
         end else begin
            check_val("launch_fields", 256'({grant_id, packet_meta_data_input}),
                      256'(exp_q.pop_front()));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [95:0] str;
      int order [5];
      str   = "here is data";
      order = '{0, 1, 2, 3, 0};

      // Reset values
      apply_reset();
      check_val("rst_busy",      256'(busy),                   256'(0));
      check_val("rst_txv",       256'(TX_valid),               256'(0));
      check_val("rst_count",     256'(tx_count),               256'(0));
      check_val("rst_grant",     256'(grant_id),               256'(0));
      check_val("rst_data",      256'(packet_data_input),      256'(0));
      check_val("rst_state",     256'(fsm_state),              256'(IDLE));
      check_val("rst_ready",     256'(req_ready),              256'(0));
      check_val("rst_timeout",   256'(timeout_err),            256'(0));

      // Single requester
      load_all();
      set_req(0, 8'h28, 64'd129, {160'd0, str});
      req_valid = 4'b0001;
      #1;
      check_val("t1_ready", 256'(req_ready), 256'(4'b0001));
      expect_launch(0, 8'h28);
      tick();
      check_val("t1_txv",    256'(TX_valid),            256'(1));
      check_val("t1_prefix", 256'(packet_prefix_input), 256'(64'd129));
      check_val("t1_data",   256'(packet_data_input),   256'({160'd0, str}));
      check_val("t1_busy",   256'(busy),                256'(1));
      req_valid = '0;
      tick();
      check_val("t1_txv_off", 256'(TX_valid),  256'(0));
      check_val("t1_wait",    256'(fsm_state), 256'(WAIT));
      req_meta[0 +: META_W] = 8'hFF;
      repeat (T1_WAIT) tick();
      check_val("t1_hold_meta", 256'(packet_meta_data_input), 256'(8'h28));
      check_val("t1_hold_busy", 256'(busy),                   256'(1));
      pulse_done();
      check_val("t1_count", 256'(tx_count), 256'(1));
      check_val("t1_idle",  256'(busy),     256'(0));

      // Round-robin order with all requesters held valid
      apply_reset();
      load_all();
      req_valid = 4'hF;
      for (int g = 0; g < 5; g++) expect_launch(order[g], meta_of(order[g]));
      for (int g = 0; g < 5; g++) begin
         wait_launch(4);
         check_val("rr_grant", 256'(grant_id), 256'(order[g]));
         repeat (5) tick();
         pulse_done();
      end
      req_valid = '0;
      check_val("rr_count", 256'(tx_count), 256'(5));

      // Spurious tx_done in IDLE and LAUNCH, then back-to-back
      apply_reset();
      req_valid = 4'b0010;
      tx_done   = 1'b1;
      #1;
      check_val("sp_ready", 256'(req_ready), 256'(4'b0010));
      expect_launch(1, meta_of(1));
      tick();
      check_val("sp_txv", 256'(TX_valid), 256'(1));
      req_valid = '0;
      tick();
      tx_done = 1'b0;
      check_val("sp_still_wait", 256'(fsm_state), 256'(WAIT));
      check_val("sp_busy",       256'(busy),      256'(1));
      check_val("sp_count",      256'(tx_count),  256'(0));
      tick();
      req_valid = 4'b0100;
      tx_done   = 1'b1;
      #1;
      check_val("b2b_ready_wait", 256'(req_ready), 256'(0));
      expect_launch(2, meta_of(2));
      tick();
      tx_done = 1'b0;
      #1;
      check_val("b2b_count1", 256'(tx_count),  256'(1));
      check_val("b2b_idle",   256'(fsm_state), 256'(IDLE));
      check_val("b2b_txv_u1", 256'(TX_valid),  256'(0));
      check_val("b2b_ready",  256'(req_ready), 256'(4'b0100));
      tick();
      check_val("b2b_txv_u2", 256'(TX_valid), 256'(1));
      check_val("b2b_grant",  256'(grant_id), 256'(2));
      req_valid = '0;
      tick();
      pulse_done();
      check_val("b2b_count2", 256'(tx_count), 256'(2));

      // Reset during WAIT
      req_valid = 4'b0100;
      expect_launch(2, meta_of(2));
      wait_launch(2);
      req_valid = '0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_val("mr_busy",  256'(busy),                   256'(0));
      check_val("mr_count", 256'(tx_count),               256'(0));
      check_val("mr_data",  256'(packet_data_input),      256'(0));
      check_val("mr_meta",  256'(packet_meta_data_input), 256'(0));
      check_val("mr_state", 256'(fsm_state),              256'(IDLE));
      check_val("mr_txv",   256'(TX_valid),               256'(0));
      req_valid = 4'hF;
      #1;
      check_val("mr_ready0", 256'(req_ready), 256'(4'b0001));
      expect_launch(0, meta_of(0));
      wait_launch(2);
      req_valid = '0;
      tick();
      pulse_done();

`ifdef SPI_ARB_TIMEOUT_EN
      // Watchdog fires after TO WAIT cycles
      apply_reset();
      req_valid = 4'b0001;
      expect_launch(0, meta_of(0));
      wait_launch(2);
      req_valid = '0;
      repeat (TO) tick();
      check_val("to_pre_err",  256'(timeout_err), 256'(0));
      check_val("to_pre_busy", 256'(busy),        256'(1));
      tick();
      check_val("to_err",   256'(timeout_err), 256'(1));
      check_val("to_busy",  256'(busy),        256'(0));
      check_val("to_count", 256'(tx_count),    256'(0));
      tick();
      check_val("to_err_pulse", 256'(timeout_err), 256'(0));
      // tx_done in the expiring cycle wins
      req_valid = 4'b0001;
      expect_launch(0, meta_of(0));
      wait_launch(2);
      req_valid = '0;
      repeat (TO) tick();
      pulse_done();
      check_val("tod_count", 256'(tx_count),    256'(1));
      check_val("tod_err",   256'(timeout_err), 256'(0));
      check_val("tod_state", 256'(fsm_state),   256'(IDLE));
`else
      // Without the watchdog a long WAIT is held
      apply_reset();
      req_valid = 4'b0001;
      expect_launch(0, meta_of(0));
      wait_launch(2);
      req_valid = '0;
      repeat (40) tick();
      check_val("nw_busy",  256'(busy),        256'(1));
      check_val("nw_err",   256'(timeout_err), 256'(0));
      check_val("nw_state", 256'(fsm_state),   256'(WAIT));
      pulse_done();
      check_val("nw_count", 256'(tx_count), 256'(1));
`endif

      // ---------------- final report ----------------
      tick();
      check_val("queue_drained", 256'(exp_q.size()), 256'(0));
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_time_limit observed=expired expected=finished");
      $fatal(1, "time limit");
   end

endmodule : tb_spi_tx_arbiter
